// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: latches decoded operands/control, resolves EX/MEM and MEM/WB
// forwarding for the ALU inputs, and inserts a single bubble on a load-use hazard.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [2:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src_b,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [2:0]        alu_operation,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              load_use_stall
);

    typedef struct packed {
        logic              valid;
        logic [2:0]        alu_op;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              alu_src_b;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] rd_addr;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } ex_fields_t;

    ex_fields_t ex_d, ex_q;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    always_comb begin
        load_use_stall = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != '0) & id_valid &
                         ((ex_q.rd_addr == id_rs_addr) | (ex_q.rd_addr == id_rt_addr));
    end

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use_stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid      = id_valid;
            ex_d.alu_op     = id_alu_op;
            ex_d.rs_data    = id_rs_data;
            ex_d.rt_data    = id_rt_data;
            ex_d.imm        = id_imm;
            ex_d.alu_src_b  = id_alu_src_b;
            ex_d.rs_addr    = id_rs_addr;
            ex_d.rt_addr    = id_rt_addr;
            ex_d.rd_addr    = id_rd_addr;
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_read   = id_mem_read;
            ex_d.mem_write  = id_mem_write;
            ex_d.mem_to_reg = id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Bypass uses live EX/MEM and MEM/WB inputs, so held operands keep tracking them during a stall.
    always_comb begin
        rs_fwd = ex_q.rs_data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs_addr) begin
            rs_fwd = exmem_result;
        end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs_addr) begin
            rs_fwd = memwb_result;
        end

        rt_fwd = ex_q.rt_data;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rt_addr) begin
            rt_fwd = exmem_result;
        end else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rt_addr) begin
            rt_fwd = memwb_result;
        end
    end

    always_comb begin
        ex_valid      = ex_q.valid;
        alu_operation = ex_q.alu_op;
        alu_a         = rs_fwd;
        alu_b         = ex_q.alu_src_b ? ex_q.imm : rt_fwd;
        ex_store_data = rt_fwd;
        ex_rd         = ex_q.rd_addr;
        ex_reg_write  = ex_q.reg_write  & ex_q.valid;
        ex_mem_read   = ex_q.mem_read   & ex_q.valid;
        ex_mem_write  = ex_q.mem_write  & ex_q.valid;
        ex_mem_to_reg = ex_q.mem_to_reg & ex_q.valid;
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg: directed vector table, hand-written hazard/stall/reset
// sequences, then randomized traffic checked against a slot-level reference model.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        id_valid;
    logic [2:0]  id_alu_op;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src_b;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        ex_valid;
    logic [2:0]  alu_operation;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src_b(id_alu_src_b),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_operation(alu_operation),
        .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_stall(load_use_stall)
    );

    // Reference model: the instruction slot currently sitting in EX.
    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [31:0] rs_d, rt_d, imm;
        logic        src_b;
        logic [4:0]  rs, rt, rd;
        logic        rw, mr, mw, mtr;
    } slot_t;

    slot_t m, bubble_slot;

    function automatic logic [31:0] newest_value(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return rf;
        if (exmem_reg_write && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd == r) return memwb_result;
        return rf;
    endfunction

    function automatic logic model_hazard();
        return m.valid && m.mr && m.rd != 5'd0 && id_valid &&
               (m.rd == id_rs_addr || m.rd == id_rt_addr);
    endfunction

    function automatic slot_t slot_from_id();
        slot_t s;
        s.valid = id_valid;  s.op = id_alu_op;
        s.rs_d = id_rs_data; s.rt_d = id_rt_data; s.imm = id_imm; s.src_b = id_alu_src_b;
        s.rs = id_rs_addr;   s.rt = id_rt_addr;   s.rd = id_rd_addr;
        s.rw = id_reg_write; s.mr = id_mem_read;  s.mw = id_mem_write; s.mtr = id_mem_to_reg;
        return s;
    endfunction

    task automatic tick();
        slot_t nxt;
        if (!rst_n || flush) nxt = bubble_slot;
        else if (stall) nxt = m;
        else if (model_hazard()) nxt = bubble_slot;
        else nxt = slot_from_id();
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] fa, fb;
        fa = newest_value(m.rs, m.rs_d);
        fb = newest_value(m.rt, m.rt_d);
        chk({tag, ".ex_valid"},       ex_valid,       m.valid);
        chk({tag, ".alu_operation"},  alu_operation,  m.op);
        chk({tag, ".alu_a"},          alu_a,          fa);
        chk({tag, ".alu_b"},          alu_b,          m.src_b ? m.imm : fb);
        chk({tag, ".ex_store_data"},  ex_store_data,  fb);
        chk({tag, ".ex_rd"},          ex_rd,          m.rd);
        chk({tag, ".ex_reg_write"},   ex_reg_write,   m.rw & m.valid);
        chk({tag, ".ex_mem_read"},    ex_mem_read,    m.mr & m.valid);
        chk({tag, ".ex_mem_write"},   ex_mem_write,   m.mw & m.valid);
        chk({tag, ".ex_mem_to_reg"},  ex_mem_to_reg,  m.mtr & m.valid);
        chk({tag, ".load_use_stall"}, load_use_stall, model_hazard());
    endtask

    task automatic set_id(input logic v, input logic [2:0] op, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm, input logic sb,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic mtr);
        id_valid = v; id_alu_op = op; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_src_b = sb; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = mtr;
    endtask

    task automatic set_byp(input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
        exmem_reg_write = xw; exmem_rd = xrd; exmem_result = xres;
        memwb_reg_write = ww; memwb_rd = wrd; memwb_result = wres;
    endtask

    typedef struct {
        string       name;
        logic        v;
        logic [2:0]  op;
        logic [31:0] rsd, rtd, imm;
        logic        sb;
        logic [4:0]  rs, rt, rd;
        logic        rw;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic        e_valid;
        logic [31:0] e_a, e_b, e_st;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bubble_slot = '{valid: 1'b0, op: 3'd0, rs_d: 32'd0, rt_d: 32'd0, imm: 32'd0, src_b: 1'b0,
                        rs: 5'd0, rt: 5'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, mtr: 1'b0};
        m = bubble_slot;

        //          name        v  op   rs_data  rt_data  imm          sb rs rt rd rw | xw xrd xres     ww wrd wres    | valid a        b            store
        vecs[0] = '{"basic",    1, 3'd1, 32'd5,  32'd7,   32'd0,       0, 1, 2, 3, 1,   0, 0, 32'h0,   0, 0, 32'h0,     1, 32'd5,   32'd7,       32'd7};
        vecs[1] = '{"imm_sel",  1, 3'd2, 32'd9,  32'd3,   32'h0000FFFF,1, 1, 2, 3, 1,   0, 0, 32'h0,   0, 0, 32'h0,     1, 32'd9,   32'h0000FFFF,32'd3};
        vecs[2] = '{"fwd_exmem",1, 3'd3, 32'h11, 32'h22,  32'd0,       0, 4, 5, 6, 1,   1, 4, 32'hAA,  1, 4, 32'hBB,    1, 32'hAA,  32'h22,      32'h22};
        vecs[3] = '{"fwd_memwb",1, 3'd3, 32'h11, 32'h22,  32'd0,       0, 4, 5, 6, 1,   0, 4, 32'hAA,  1, 4, 32'hBB,    1, 32'hBB,  32'h22,      32'h22};
        vecs[4] = '{"no_fwd_r0",1, 3'd3, 32'h11, 32'h22,  32'd0,       0, 4, 5, 6, 1,   1, 0, 32'hAA,  1, 0, 32'hBB,    1, 32'h11,  32'h22,      32'h22};
        vecs[5] = '{"fwd_rt",   1, 3'd4, 32'h11, 32'h22,  32'h99,      0, 4, 5, 6, 1,   1, 5, 32'hCC,  1, 5, 32'hDD,    1, 32'h11,  32'hCC,      32'hCC};
        vecs[6] = '{"invalid",  0, 3'd5, 32'h1,  32'h2,   32'd0,       0, 1, 2, 7, 1,   0, 0, 32'h0,   0, 0, 32'h0,     0, 32'h1,   32'h2,       32'h2};

        // Reset held with ID active: everything must stay zero.
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(1, 3'd7, 32'hDEAD, 32'hBEEF, 32'h1234, 1, 5'd3, 5'd3, 5'd3, 1, 1, 1, 1);
        set_byp(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        tick(); tick();
        chk("rst.ex_valid", ex_valid, 0);
        chk("rst.alu_operation", alu_operation, 0);
        chk("rst.alu_a", alu_a, 0);
        chk("rst.ex_rd", ex_rd, 0);
        chk("rst.ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
        chk("rst.load_use_stall", load_use_stall, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            set_id(vecs[i].v, vecs[i].op, vecs[i].rsd, vecs[i].rtd, vecs[i].imm, vecs[i].sb,
                   vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rw, 0, 0, 0);
            set_byp(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            tick();
            set_byp(vecs[i].xw, vecs[i].xrd, vecs[i].xres, vecs[i].ww, vecs[i].wrd, vecs[i].wres);
            #1;
            chk({vecs[i].name, ".ex_valid"}, ex_valid, vecs[i].e_valid);
            chk({vecs[i].name, ".alu_operation"}, alu_operation, vecs[i].op);
            chk({vecs[i].name, ".alu_a"}, alu_a, vecs[i].e_a);
            chk({vecs[i].name, ".alu_b"}, alu_b, vecs[i].e_b);
            chk({vecs[i].name, ".ex_store_data"}, ex_store_data, vecs[i].e_st);
            chk({vecs[i].name, ".ex_rd"}, ex_rd, vecs[i].rd);
            chk({vecs[i].name, ".ex_reg_write"}, ex_reg_write, vecs[i].rw & vecs[i].e_valid);
        end

        // Load-use: lw r8 in EX, add r9,r8,r1 in ID.
        set_byp(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        set_id(1, 3'd0, 32'h100, 32'h0, 32'h8, 1, 5'd2, 5'd8, 5'd8, 1, 1, 0, 1);
        tick();
        chk("lu.ex_mem_read", ex_mem_read, 1);
        set_id(1, 3'd1, 32'h55, 32'h66, 32'h0, 0, 5'd8, 5'd1, 5'd9, 1, 0, 0, 0);
        #1;
        chk("lu.load_use_stall", load_use_stall, 1);
        tick();
        chk("lu.bubble_valid", ex_valid, 0);
        chk("lu.bubble_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
        chk("lu.stall_drops", load_use_stall, 0);
        set_byp(1, 5'd8, 32'h1234, 0, 5'd0, 32'd0);
        tick();
        chk("lu.captured_valid", ex_valid, 1);
        chk("lu.captured_rd", ex_rd, 9);
        chk("lu.fwd_alu_a", alu_a, 32'h1234);
        chk("lu.alu_b", alu_b, 32'h66);

        // Stall holds fields while the bypass value keeps changing.
        stall = 1'b1;
        set_id(1, 3'd6, 32'h77, 32'h77, 32'h0, 0, 5'd2, 5'd3, 5'd4, 0, 0, 0, 0);
        for (int unsigned k = 0; k < 3; k++) begin
            set_byp(0, 5'd8, 32'h0, 1, 5'd8, 32'hC000 + k);
            tick();
            chk("stall.ex_rd", ex_rd, 9);
            chk("stall.alu_operation", alu_operation, 1);
            chk("stall.alu_a_tracks", alu_a, 32'hC000 + k);
        end
        flush = 1'b1;
        tick();
        chk("flush_over_stall.valid", ex_valid, 0);
        chk("flush_over_stall.reg_write", ex_reg_write, 0);
        stall = 1'b0; flush = 1'b0;

        // Async reset between edges.
        set_byp(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        set_id(1, 3'd2, 32'h5, 32'h6, 32'h0, 0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);
        tick();
        chk("arst.pre_valid", ex_valid, 1);
        chk("arst.pre_reg_write", ex_reg_write, 1);
        #2 rst_n = 1'b0;
        m = bubble_slot;
        #1;
        chk("arst.valid", ex_valid, 0);
        chk("arst.reg_write", ex_reg_write, 0);
        #1 rst_n = 1'b1;
        tick();
        chk("arst.first_capture", ex_valid, 1);
        chk("arst.first_capture_a", alu_a, 32'h5);

        // Randomized traffic against the model; small register range to provoke hazards.
        for (int unsigned n = 0; n < 400; n++) begin
            set_id(($urandom % 4) != 0, 3'($urandom), $urandom, $urandom, $urandom,
                   1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), ($urandom % 3) == 0,
                   1'($urandom), 1'($urandom));
            set_byp(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            stall = ($urandom % 8) == 0;
            flush = ($urandom % 12) == 0;
            #1;
            check_model("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage core; sits directly upstream of the EX-stage ALU.
- Latches decoded operands and control from ID.
- Resolves EX/MEM and MEM/WB operand forwarding, then drives the ALU's 3-bit operation and 32-bit A/B inputs.
- Detects load-use hazards and inserts one bubble per hazard.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold the current EX contents (downstream stall)
flush  in  1  squash: load a bubble
id_valid  in  1  ID holds a real instruction
id_alu_op  in  3  ALU operation code
id_rs_data  in  DATA_W  register-file rs read data
id_rt_data  in  DATA_W  register-file rt read data
id_imm  in  DATA_W  extended immediate
id_alu_src_b  in  1  1: B = imm, 0: B = rt
id_rs_addr  in  REG_AW  rs index
id_rt_addr  in  REG_AW  rt index
id_rd_addr  in  REG_AW  destination index
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  REG_AW  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  REG_AW  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB writeback data
ex_valid  out  1  EX holds a real instruction
alu_operation  out  3  to ALU
alu_a  out  DATA_W  to ALU A
alu_b  out  DATA_W  to ALU B
ex_store_data  out  DATA_W  forwarded rt for stores
ex_rd  out  REG_AW  destination index
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control, gated by ex_valid
load_use_stall  out  1  to IF/ID: hold fetch/decode

Behaviour:
- Reset (rst_n low, asynchronous): all registered fields are 0. Therefore ex_valid=0, all control outs=0, alu_operation=000, ex_rd=0, and load_use_stall=0.
- load_use_stall (combinational) = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs_addr | ex_rd==id_rt_addr).
- Update priority at each posedge clk:
  1. flush: bubble.
  2. stall: hold every field.
  3. load_use_stall: bubble.
  4. Otherwise capture all id_* fields; ex_valid <= id_valid.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_mem_to_reg are all 0. Data fields are don't-care and are set to 0.
- Control outputs are registered values ANDed with ex_valid. An invalid slot never writes.
- Forwarding (combinational, from the registered rs/rt and current-cycle bypass inputs), per operand:
  - If exmem_reg_write & exmem_rd!=0 & exmem_rd==addr, use exmem_result.
  - Else if memwb_reg_write & memwb_rd!=0 & memwb_rd==addr, use memwb_result.
  - Else use the registered register-file data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- alu_a = forwarded rs.
- alu_b = registered imm if alu_src_b=1, else forwarded rt.
- ex_store_data = forwarded rt, regardless of alu_src_b.
- alu_operation = registered op. Forwarding is live during stall: held operands track the current bypass sources.
- Latency: one cycle from ID capture to ALU inputs.
- A load-use hazard produces exactly one bubble. The next cycle the load has moved to MEM, load_use_stall drops, and the dependent instruction captures and forwards from EX/MEM.
- Reset mid-operation clears immediately; the first capture happens on the first clk edge after rst_n rises.

Test Plan:
1. Reset: hold rst_n=0 with id_* active -> all outputs 0, load_use_stall=0. Release, id_valid=1, op=001, rs=5, rt=7 -> next cycle alu_operation=001, alu_a=5, alu_b=7, ex_valid=1.
2. Immediate select: id_alu_src_b=1, imm=0x0000FFFF, rt_data=3 -> alu_b=0x0000FFFF, ex_store_data=3.
3. Forward priority: EX rs=r4; exmem(rd=4, result=0xAA, we=1) and memwb(rd=4, result=0xBB, we=1) -> alu_a=0xAA. Drop exmem_reg_write -> alu_a=0xBB. Set rd=0 for both -> alu_a=register data.
4. Load-use: EX holds lw with rd=r8; ID has add r9,r8,r1 -> load_use_stall=1. Next cycle ex_valid=0 and all control 0. Following cycle, add captured; with exmem_rd=8, exmem_result=0x1234 -> alu_a=0x1234.
5. Stall vs flush: stall=1 for 3 cycles -> EX fields unchanged, alu_a follows a changing memwb_result for the matching reg. Assert flush and stall together -> bubble (flush wins).
6. Async reset mid-stream: drop rst_n between clock edges while ex_valid=1, ex_reg_write=1 -> both go 0 immediately without waiting for a clock edge.
